vga_pixel_write_ctrl: RTL and testbench
=======================================

// Module: vga_pixel_write_ctrl
// PURPOSE
//  Consumes the 4-bit pixel-status command word driven by the Nios pixel_status_write PIO.
//  Executes single-pixel writes or full-screen fills into the VGA frame-buffer write port.
//  Returns busy/ack/err to software through a 3-bit status word for an input PIO.
//  Sits between the Avalon PIO layer and the frame-buffer RAM arbiter.
// PARAMETERS
//  ADDR_W    17     frame-buffer address width
//  COLOR_W   8      pixel colour width
//  FB_DEPTH  76800  number of pixels (320x240); valid addresses 0..FB_DEPTH-1
// PORTS
//  clk           in   1        system clock; the block's only clock
//  reset_n       in   1        asynchronous, active-low reset
//  pio_status    in   4        [0] WR toggle, [1] FILL toggle, [2] ABORT level, [3] ENABLE level
//  pio_addr      in   ADDR_W   target pixel address, from PIO
//  pio_color     in   COLOR_W  pixel/fill colour, from PIO
//  fb_ready      in   1        arbiter accepts a write this cycle
//  fb_wr_en      out  1        write request to frame buffer
//  fb_addr       out  ADDR_W   write address
//  fb_wdata      out  COLOR_W  write data
//  status_out    out  3        [0] busy, [1] ack toggle, [2] err (sticky)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; seen_wr = seen_fill = 0; fill counter 0.
//  Request detect, IDLE only:
//   - WR request when pio_status[0] != seen_wr.
//   - FILL request when pio_status[1] != seen_fill.
//   - On a request, seen_* <= pio_status[1:0]; pio_addr and pio_color are latched in the same cycle.
//  ENABLE=0 in IDLE:
//   - seen_* track pio_status every cycle; no operation starts.
//   - Toggles made while disabled are discarded.
//  FSM states: IDLE, WRITE, FILL, DONE.
//   - IDLE -> FILL when a FILL request is detected (FILL has priority).
//     Set fill counter 0; clear err.
//     A WR request toggled in the same cycle is consumed and not executed.
//   - IDLE -> WRITE when only a WR request is detected; clear err.
//     If latched addr >= FB_DEPTH: go straight to DONE, set err; no fb write.
//   - WRITE: fb_wr_en=1, fb_addr=latched addr, fb_wdata=latched colour.
//     Hold until fb_ready=1; that cycle completes the beat; next state DONE.
//   - FILL: fb_wr_en=1, fb_addr=counter, fb_wdata=latched colour.
//     Each fb_ready=1 cycle increments the counter.
//     The beat at counter FB_DEPTH-1 -> DONE; the counter never wraps.
//   - DONE: one cycle; ack toggles; -> IDLE.
//  Latency: a request on cycle N gives fb_wr_en on N+1.
//   - Single write with fb_ready held 1: ack flips on N+3.
//   - Fill with fb_ready held 1: ack flips on N+FB_DEPTH+2.
//  Busy: status_out[0]=1 in WRITE, FILL and DONE.
//  Toggles while busy: seen_* are frozen, so a net change is serviced on return to IDLE.
//  An even number of toggles while busy is lost (software contract: wait for ack).
//  ABORT=1 in WRITE/FILL:
//   - fb_wr_en drops the next cycle; -> DONE; ack toggles; err set.
//   - A beat accepted in the abort cycle itself stands.
//  ABORT is ignored in IDLE.
//  fb_addr/fb_wdata hold their last value when fb_wr_en=0.
//  Reset mid-operation: immediate return to reset values; no ack is produced.
// STRUCTURE
//  Shared package vga_pkg:
//   - state encoding localparams ST_IDLE/ST_WRITE/ST_FILL/ST_DONE.
//   - pio_status bit indices (BIT_WR, BIT_FILL, BIT_ABORT, BIT_EN).
//   - status_out bit indices.
//  One sub-module: vga_toggle_detect.
//   - Per-bit seen register with freeze and track inputs; flags a change.
//   - Instantiated twice (WR and FILL). FSM, counter and datapath stay in this module.
// TESTING
//  1. Reset; ENABLE=1, addr=100, color=0x3C, toggle WR; fb_ready=1.
//     -> one fb_wr_en beat at 100/0x3C on N+1; ack=1 on N+3; busy=0 after.
//  2. FB_DEPTH=16 build; toggle FILL, color=0xFF, fb_ready=1.
//     -> 16 beats, addr 0..15; ack flips once; counter stops at 15.
//  3. Single write with fb_ready low for 5 cycles.
//     -> fb_wr_en, addr and data held stable 5 cycles; ack after ready.
//  4. Toggle WR and FILL in the same cycle.
//     -> fill only; no single write; one ack toggle.
//  5. addr=FB_DEPTH, toggle WR.
//     -> no fb_wr_en; err=1; ack toggles. Next valid WR clears err.
//  6. ABORT mid-fill at beat 5.
//     -> wr_en low next cycle; err=1; ack toggles.
//     Also: reset_n low mid-fill -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-write controller slice.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // pio_status bit positions
  localparam int unsigned BIT_WR    = 0;
  localparam int unsigned BIT_FILL  = 1;
  localparam int unsigned BIT_ABORT = 2;
  localparam int unsigned BIT_EN    = 3;

  // status_out bit positions
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_ACK  = 1;
  localparam int unsigned STAT_ERR  = 2;

endpackage

// File: rtl/vga_toggle_detect.sv
// Per-bit toggle detector: remembers the last seen level of a software
// toggle bit and flags when the live level differs from it.
module vga_toggle_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  input  logic freeze,
  input  logic track,
  output logic changed
);

  logic seen;

  assign changed = sig ^ seen;

  // Seen level follows the input while tracking; held while frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen <= 1'b0;
    end else if (!freeze && track) begin
      seen <= sig;
    end
  end

endmodule

// File: rtl/vga_pixel_write_ctrl.sv
// Frame-buffer write controller driven by the Nios pixel_status PIO:
// single-pixel writes and full-screen fills, with busy/ack/err status.
module vga_pixel_write_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned FB_DEPTH = 76800
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         pio_status,
  input  logic [ADDR_W-1:0]  pio_addr,
  input  logic [COLOR_W-1:0] pio_color,
  input  logic               fb_ready,
  output logic               fb_wr_en,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic [2:0]         status_out
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_DEPTH - 1);

  state_t            state, state_nxt;
  logic              enable, abort;
  logic              wr_chg, fill_chg, req_any, freeze, track;
  logic              start_fill, start_wr, start_bad;
  logic [ADDR_W-1:0] cnt;
  logic              ack, err;

  assign enable  = pio_status[BIT_EN];
  assign abort   = pio_status[BIT_ABORT];
  assign freeze  = (state != ST_IDLE);
  assign req_any = enable & (wr_chg | fill_chg);
  // While disabled the seen bits shadow the PIO so toggles are discarded;
  // on a request both bits are captured, consuming a simultaneous WR.
  assign track   = ~enable | req_any;

  vga_toggle_detect u_det_wr (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (pio_status[BIT_WR]),
    .freeze  (freeze),
    .track   (track),
    .changed (wr_chg)
  );

  vga_toggle_detect u_det_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (pio_status[BIT_FILL]),
    .freeze  (freeze),
    .track   (track),
    .changed (fill_chg)
  );

  // Next-state and operation-start decode.
  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    start_wr   = 1'b0;
    start_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          if (fill_chg) begin
            start_fill = 1'b1;
            state_nxt  = ST_FILL;
          end else if (wr_chg) begin
            if (pio_addr >= DEPTH_A) begin
              start_bad = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              start_wr  = 1'b1;
              state_nxt = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (abort || fb_ready) state_nxt = ST_DONE;
      end
      ST_FILL: begin
        if (abort || (fb_ready && cnt == LAST_A)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Write port, fill counter and status flags; fb_addr/fb_wdata double as
  // the request latches so they hold their value between beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      fb_wr_en <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (start_fill) begin
        cnt      <= '0;
        fb_addr  <= '0;
        fb_wdata <= pio_color;
        fb_wr_en <= 1'b1;
        err      <= 1'b0;
      end
      if (start_wr) begin
        fb_addr  <= pio_addr;
        fb_wdata <= pio_color;
        fb_wr_en <= 1'b1;
        err      <= 1'b0;
      end
      if (start_bad) begin
        err <= 1'b1;
      end
      if (state == ST_FILL && fb_ready && !abort && cnt != LAST_A) begin
        cnt     <= cnt + 1'b1;
        fb_addr <= cnt + 1'b1;
      end
      if ((state == ST_WRITE || state == ST_FILL) && state_nxt == ST_DONE) begin
        fb_wr_en <= 1'b0;
        if (abort) err <= 1'b1;
      end
      if (state == ST_DONE) begin
        ack <= ~ack;
      end
    end
  end

  // Status word for the input PIO.
  always_comb begin
    status_out            = '0;
    status_out[STAT_BUSY] = (state != ST_IDLE);
    status_out[STAT_ACK]  = ack;
    status_out[STAT_ERR]  = err;
  end

endmodule

// File: tb/tb_vga_pixel_write_ctrl.sv
// Directed bench: a full-size instance for single writes and address range,
// a 16-pixel instance for fill, priority, abort and reset corner cases.
module tb_vga_pixel_write_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pio_a, pio_b;
  logic [16:0] addr;
  logic [7:0]  color;
  logic        ready;

  logic        wr_a, wr_b;
  logic [16:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic [2:0]  st_a, st_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_ack_a = 1'b0;
  logic exp_ack_b = 1'b0;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  c;
    bit          bad;
  } wvec_t;

  wvec_t tbl [7];

  always #5 clk = ~clk;

  vga_pixel_write_ctrl #(.ADDR_W(17), .COLOR_W(8), .FB_DEPTH(76800)) dut_big (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_status (pio_a),
    .pio_addr   (addr),
    .pio_color  (color),
    .fb_ready   (ready),
    .fb_wr_en   (wr_a),
    .fb_addr    (addr_a),
    .fb_wdata   (data_a),
    .status_out (st_a)
  );

  vga_pixel_write_ctrl #(.ADDR_W(17), .COLOR_W(8), .FB_DEPTH(16)) dut_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_status (pio_b),
    .pio_addr   (addr),
    .pio_color  (color),
    .fb_ready   (ready),
    .fb_wr_en   (wr_b),
    .fb_addr    (addr_b),
    .fb_wdata   (data_b),
    .status_out (st_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{17'd0,      8'h01, 1'b0};
    tbl[1] = '{17'd100,    8'h3C, 1'b0};
    tbl[2] = '{17'd76799,  8'hA5, 1'b0};
    tbl[3] = '{17'd76800,  8'h77, 1'b1};
    tbl[4] = '{17'd42,     8'h0F, 1'b0};
    tbl[5] = '{17'd131071, 8'hEE, 1'b1};
    tbl[6] = '{17'd7,      8'h80, 1'b0};

    reset_n = 1'b0;
    pio_a   = 4'b1000;
    pio_b   = 4'b1000;
    addr    = '0;
    color   = '0;
    ready   = 1'b1;
    #12;
    chk("reset_wr_en",  {31'd0, wr_a}, 32'd0);
    chk("reset_status", {29'd0, st_a}, 32'd0);
    chk("reset_addr",   {15'd0, addr_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Toggle while disabled is discarded, also after re-enable.
    pio_a[3] = 1'b0;
    pio_a[0] = ~pio_a[0];
    tick();
    chk("dis_wr_en", {31'd0, wr_a}, 32'd0);
    chk("dis_busy",  {31'd0, st_a[0]}, 32'd0);
    pio_a[3] = 1'b1;
    tick();
    tick();
    chk("reen_wr_en", {31'd0, wr_a}, 32'd0);
    chk("reen_busy",  {31'd0, st_a[0]}, 32'd0);

    // Table of single writes, fb_ready held high.
    for (int i = 0; i < 7; i++) begin
      addr     = tbl[i].a;
      color    = tbl[i].c;
      pio_a[0] = ~pio_a[0];
      tick();
      if (!tbl[i].bad) begin
        chk("wr_en_n1", {31'd0, wr_a}, 32'd1);
        chk("addr_n1",  {15'd0, addr_a}, {15'd0, tbl[i].a});
        chk("data_n1",  {24'd0, data_a}, {24'd0, tbl[i].c});
        chk("busy_n1",  {31'd0, st_a[0]}, 32'd1);
        tick();
        chk("wr_en_n2", {31'd0, wr_a}, 32'd0);
        chk("busy_n2",  {31'd0, st_a[0]}, 32'd1);
        chk("ack_n2",   {31'd0, st_a[1]}, {31'd0, exp_ack_a});
        tick();
        exp_ack_a = ~exp_ack_a;
        chk("ack_n3",   {31'd0, st_a[1]}, {31'd0, exp_ack_a});
        chk("busy_n3",  {31'd0, st_a[0]}, 32'd0);
        chk("err_n3",   {31'd0, st_a[2]}, 32'd0);
      end else begin
        chk("bad_wr_en", {31'd0, wr_a}, 32'd0);
        chk("bad_busy",  {31'd0, st_a[0]}, 32'd1);
        tick();
        exp_ack_a = ~exp_ack_a;
        chk("bad_ack",   {31'd0, st_a[1]}, {31'd0, exp_ack_a});
        chk("bad_err",   {31'd0, st_a[2]}, 32'd1);
        chk("bad_busy2", {31'd0, st_a[0]}, 32'd0);
        chk("bad_wr_en2", {31'd0, wr_a}, 32'd0);
      end
    end

    // Write held off by fb_ready low for five cycles.
    ready    = 1'b0;
    addr     = 17'd200;
    color    = 8'h55;
    pio_a[0] = ~pio_a[0];
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_wr_en", {31'd0, wr_a}, 32'd1);
      chk("stall_addr",  {15'd0, addr_a}, 32'd200);
      chk("stall_data",  {24'd0, data_a}, 32'h55);
      tick();
    end
    chk("stall_ack_held", {31'd0, st_a[1]}, {31'd0, exp_ack_a});
    ready = 1'b1;
    tick();
    chk("stall_done_wr_en", {31'd0, wr_a}, 32'd0);
    tick();
    exp_ack_a = ~exp_ack_a;
    chk("stall_ack", {31'd0, st_a[1]}, {31'd0, exp_ack_a});

    // Full fill of the 16-pixel buffer.
    color    = 8'hFF;
    pio_b[1] = ~pio_b[1];
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("fill_wr_en", {31'd0, wr_b}, 32'd1);
      chk("fill_addr",  {15'd0, addr_b}, i);
      chk("fill_data",  {24'd0, data_b}, 32'hFF);
      tick();
    end
    chk("fill_end_wr_en", {31'd0, wr_b}, 32'd0);
    chk("fill_end_addr",  {15'd0, addr_b}, 32'd15);
    chk("fill_end_ack",   {31'd0, st_b[1]}, {31'd0, exp_ack_b});
    tick();
    exp_ack_b = ~exp_ack_b;
    chk("fill_ack",  {31'd0, st_b[1]}, {31'd0, exp_ack_b});
    chk("fill_busy", {31'd0, st_b[0]}, 32'd0);

    // WR and FILL toggled together: fill only.
    addr       = 17'd3;
    color      = 8'h11;
    pio_b[1:0] = pio_b[1:0] ^ 2'b11;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("both_addr", {15'd0, addr_b}, i);
      chk("both_data", {24'd0, data_b}, 32'h11);
      tick();
    end
    chk("both_end_wr_en", {31'd0, wr_b}, 32'd0);
    tick();
    exp_ack_b = ~exp_ack_b;
    chk("both_ack", {31'd0, st_b[1]}, {31'd0, exp_ack_b});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("both_no_write", {31'd0, wr_b}, 32'd0);
      chk("both_idle",     {31'd0, st_b[0]}, 32'd0);
    end
    chk("both_ack_once", {31'd0, st_b[1]}, {31'd0, exp_ack_b});

    // ABORT raised while beat 5 is on the port.
    color    = 8'h5A;
    pio_b[1] = ~pio_b[1];
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("abort_pre_addr", {15'd0, addr_b}, i);
      if (i < 5) tick();
    end
    pio_b[2] = 1'b1;
    tick();
    pio_b[2] = 1'b0;
    chk("abort_wr_en", {31'd0, wr_b}, 32'd0);
    chk("abort_err",   {31'd0, st_b[2]}, 32'd1);
    chk("abort_busy",  {31'd0, st_b[0]}, 32'd1);
    tick();
    exp_ack_b = ~exp_ack_b;
    chk("abort_ack",  {31'd0, st_b[1]}, {31'd0, exp_ack_b});
    chk("abort_idle", {31'd0, st_b[0]}, 32'd0);

    // Reset in the middle of a fill.
    color    = 8'h22;
    pio_b[1] = ~pio_b[1];
    tick();
    tick();
    tick();
    chk("rst_pre_wr_en", {31'd0, wr_b}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_wr_en",   {31'd0, wr_b}, 32'd0);
    chk("rst_addr",    {15'd0, addr_b}, 32'd0);
    chk("rst_data",    {24'd0, data_b}, 32'd0);
    chk("rst_status",  {29'd0, st_b}, 32'd0);
    chk("rst_status_big", {29'd0, st_a}, 32'd0);
    pio_a = 4'b1000;
    pio_b = 4'b1000;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_wr_en",  {31'd0, wr_b}, 32'd0);
    chk("post_rst_status", {29'd0, st_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
